knn_bus_initiator: RTL

//  Native-bus initiator that drives the KNN distance peripheral. Programs a test point,

---
 rtl/knn_bus_initiator.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/knn_bus_initiator.sv
// Bus initiator for the KNN distance peripheral: programs the test point, streams
// training points, reads each distance back and keeps a sorted K-nearest list.
module knn_bus_initiator #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int K        = 4,
  parameter int IDX_W    = 8,
  parameter int A_RESET  = 0,
  parameter int A_ENABLE = 1,
  parameter int A_X      = 2,
  parameter int A_Y      = 3,
  parameter int A_DIST   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     test_pt_i,
  input  logic                  pt_valid_i,
  output logic                  pt_ready_o,
  input  logic [DATA_W-1:0]     pt_data_i,
  input  logic                  pt_last_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [K*DATA_W-1:0]   nn_dist_o,
  output logic [K*IDX_W-1:0]    nn_idx_o,
  output logic [4:0]            nn_cnt_o,
  output logic                  valid_o,
  output logic [ADDR_W-1:0]     address_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W/8-1:0]   wstrb_o,
  input  logic [DATA_W-1:0]     rdata_i,
  input  logic                  ready_i
);
  localparam int SW = DATA_W/8;

  typedef enum logic [3:0] {
    S_IDLE, S_RST1, S_RST0, S_EN, S_WRX, S_WAITP, S_WRY, S_RDD, S_INS, S_DIS, S_DONE
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SW-1:0]     wstrb;
  } bus_req_t;

  function automatic bus_req_t wr(input int a, input logic [DATA_W-1:0] v);
    bus_req_t r;
    r.valid = 1'b1; r.addr = ADDR_W'(a); r.wdata = v; r.wstrb = '1;
    return r;
  endfunction

  function automatic bus_req_t rd(input int a);
    bus_req_t r;
    r.valid = 1'b1; r.addr = ADDR_W'(a); r.wdata = '0; r.wstrb = '0;
    return r;
  endfunction

  state_t                       state_q;
  bus_req_t                     req_q;
  logic                         gap_q, busy_q, done_q, pt_ready_q, last_q;
  logic [DATA_W-1:0]            test_q, pt_q, d_q;
  logic [K-1:0][DATA_W-1:0]     dist_q, dist_d;
  logic [K-1:0][IDX_W-1:0]      sidx_q, sidx_d;
  logic [4:0]                   cnt_q, cnt_d, p;
  logic [IDX_W-1:0]             idx_q;

  // p = number of valid slots not farther than d; equal distances keep the older entry first
  always_comb begin
    p      = '0;
    dist_d = dist_q;
    sidx_d = sidx_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < K; i++)
      if (5'(i) < cnt_q && dist_q[i] <= d_q) p = p + 5'd1;
    if (p < 5'(K)) begin
      for (int i = 1; i < K; i++)
        if (5'(i) > p) begin
          dist_d[i] = dist_q[i-1];
          sidx_d[i] = sidx_q[i-1];
        end
      for (int i = 0; i < K; i++)
        if (5'(i) == p) begin
          dist_d[i] = d_q;
          sidx_d[i] = idx_q;
        end
      cnt_d = (cnt_q < 5'(K)) ? cnt_q + 5'd1 : cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      gap_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pt_ready_q <= 1'b0;
      last_q     <= 1'b0;
      test_q     <= '0;
      pt_q       <= '0;
      d_q        <= '0;
      dist_q     <= '1;
      sidx_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          state_q <= S_RST1;
          req_q   <= wr(A_RESET, DATA_W'(1));
          busy_q  <= 1'b1;
          test_q  <= test_pt_i;
          dist_q  <= '1;
          sidx_q  <= '0;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
        S_WAITP: if (pt_valid_i) begin
          pt_q       <= pt_data_i;
          last_q     <= pt_last_i;
          pt_ready_q <= 1'b0;
          state_q    <= S_WRY;
          req_q      <= wr(A_Y, pt_data_i);
        end
        S_INS: begin
          dist_q <= dist_d;
          sidx_q <= sidx_d;
          cnt_q  <= cnt_d;
          idx_q  <= idx_q + 1'b1;
          if (last_q) begin
            state_q <= S_DIS;
            req_q   <= wr(A_ENABLE, '0);
          end else begin
            state_q    <= S_WAITP;
            pt_ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          // ready is registered by the slave, so it is still high in the cycle after completion
          if (req_q.valid && ready_i) begin
            req_q.valid <= 1'b0;
            gap_q       <= 1'b1;
            if (state_q == S_RDD) d_q <= rdata_i;
          end else if (gap_q) begin
            gap_q <= 1'b0;
            case (state_q)
              S_RST1: begin state_q <= S_RST0; req_q <= wr(A_RESET, '0); end
              S_RST0: begin state_q <= S_EN;   req_q <= wr(A_ENABLE, DATA_W'(1)); end
              S_EN:   begin state_q <= S_WRX;  req_q <= wr(A_X, test_q); end
              S_WRX:  begin state_q <= S_WAITP; pt_ready_q <= 1'b1; end
              S_WRY:  begin state_q <= S_RDD;  req_q <= rd(A_DIST); end
              S_RDD:  state_q <= S_INS;
              S_DIS:  begin state_q <= S_DONE; done_q <= 1'b1; end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign pt_ready_o = pt_ready_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign nn_dist_o  = dist_q;
  assign nn_idx_o   = sidx_q;
  assign nn_cnt_o   = cnt_q;
  assign valid_o    = req_q.valid;
  assign address_o  = req_q.addr;
  assign wdata_o    = req_q.wdata;
  assign wstrb_o    = req_q.wstrb;

endmodule
